// File: rtl/mem_access_ctrl_pkg.sv
// Shared codes for the MEM-stage data-bus controller.
// Size codes follow the load/store size field.
package mem_access_ctrl_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

endpackage

// File: rtl/mem_access_ctrl_wdata_align.sv
// Store byte-lane alignment: strobes and replicated
// write data from size and the low address bits.
module mem_wdata_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        wr,
   input  logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] rep_wdata
);

   logic [3:0] strb;

   always_comb begin
      strb      = 4'b1111;
      rep_wdata = wdata;
      case (size)
         SIZE_B: begin
            strb      = 4'b0001 << addr_lo;
            rep_wdata = {4{wdata[7:0]}};
         end
         SIZE_H: begin
            strb      = addr_lo[1] ? 4'b1100 : 4'b0011;
            rep_wdata = {2{wdata[15:0]}};
         end
         default: begin
            strb      = 4'b1111;
            rep_wdata = wdata;
         end
      endcase
   end

   assign wstrb = wr ? strb : 4'b0000;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus access sequencer with stall,
// load-data hold and flush drain.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mem_valid,
   input  logic              mem_wr,
   input  logic [1:0]        mem_size,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              addr_err,
   input  logic              flush,
   input  logic              stall_other,
   output logic              mem_stall,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata
);

   state_t            state;
   logic              cancel;
   logic              start;
   logic              done;
   logic              kill;
   logic [3:0]        al_wstrb;
   logic [DATA_W-1:0] al_wdata;

   assign start = mem_valid & ~addr_err & ~flush;
   assign done  = (state == S_REQ && data_addr_ok && data_data_ok)
               || (state == S_WAIT && data_data_ok);
   assign kill  = cancel | flush;

   assign mem_stall = (state == S_REQ) || (state == S_WAIT)
                   || (state == S_IDLE && start);

   mem_wdata_align u_align (
      .size      (mem_size),
      .addr_lo   (mem_addr[1:0]),
      .wr        (mem_wr),
      .wdata     (mem_wdata),
      .wstrb     (al_wstrb),
      .rep_wdata (al_wdata)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         cancel      <= 1'b0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         data_req    <= 1'b0;
         data_wr     <= 1'b0;
         data_size   <= '0;
         data_addr   <= '0;
         data_wstrb  <= '0;
         data_wdata  <= '0;
      end else begin
         rdata_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  data_req   <= 1'b1;
                  data_wr    <= mem_wr;
                  data_size  <= mem_size;
                  data_addr  <= mem_addr;
                  data_wstrb <= al_wstrb;
                  data_wdata <= al_wdata;
                  state      <= S_REQ;
               end
            end
            S_REQ, S_WAIT: begin
               if (flush) cancel <= 1'b1;
               if (state == S_REQ && data_addr_ok)
                  data_req <= 1'b0;
               // a cancelled access still drains to data_ok
               if (done) begin
                  cancel <= 1'b0;
                  if (!kill) begin
                     if (!data_wr) rdata <= data_rdata;
                     rdata_valid <= 1'b1;
                     state <= stall_other ? S_HOLD : S_IDLE;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (state == S_REQ && data_addr_ok) begin
                  state <= S_WAIT;
               end
            end
            S_HOLD: begin
               if (flush || !stall_other) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a
// transaction-level model of bus requests and load data.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid, mem_wr, addr_err, flush;
   logic        stall_other;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_stall, rdata_valid;
   logic [31:0] rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk          (clk),
      .resetn       (resetn),
      .mem_valid    (mem_valid),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .addr_err     (addr_err),
      .flush        (flush),
      .stall_other  (stall_other),
      .mem_stall    (mem_stall),
      .rdata        (rdata),
      .rdata_valid  (rdata_valid),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      int          a, d, f, h, gap;
      logic [31:0] rd;
   } op_t;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } req_t;

   int          n_chk = 0;
   int          n_fail = 0;
   req_t        req_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] last_rd = '0;
   op_t         ops[$];
   req_t        mon_e;
   logic [31:0] mon_r;

   task automatic chk(string nm, logic [31:0] act,
                      logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // bytes-per-access arithmetic, independent of any lane table
   function automatic req_t model(op_t o);
      req_t r;
      int nb, off;
      nb  = (o.size == 2'd0) ? 1 : (o.size == 2'd1) ? 2 : 4;
      off = (int'(o.addr[1:0]) / nb) * nb;
      r.wr   = o.wr;
      r.size = o.size;
      r.addr = o.addr;
      r.strb = o.wr ? 4'(((1 << nb) - 1) << off) : 4'b0000;
      for (int b = 0; b < 4; b++)
         r.wdata[8*b +: 8] = o.wdata[8*(b % nb) +: 8];
      return r;
   endfunction

   always @(negedge clk) begin
      if (resetn) begin
         if (data_req && data_addr_ok) begin
            if (req_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL req_unexpected: got %h expected none",
                        data_addr);
            end else begin
               mon_e = req_q.pop_front();
               chk("req_addr", data_addr, mon_e.addr);
               chk("req_wr", 32'(data_wr), 32'(mon_e.wr));
               chk("req_size", 32'(data_size), 32'(mon_e.size));
               chk("req_wstrb", 32'(data_wstrb), 32'(mon_e.strb));
               if (mon_e.wr)
                  chk("req_wdata", data_wdata, mon_e.wdata);
            end
         end
         if (rdata_valid) begin
            if (rd_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rvalid_unexpected: got %h expected none",
                        rdata);
            end else begin
               mon_r = rd_q.pop_front();
               chk("rdata", rdata, mon_r);
            end
         end
      end
   end

   task automatic apply(op_t o);
      mem_valid = 1'b1;
      mem_wr    = o.wr;
      mem_size  = o.size;
      mem_addr  = o.addr;
      mem_wdata = o.wdata;
      addr_err  = o.err;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(op_t o, op_t nx);
      bit cancelled;
      apply(o);
      @(negedge clk);
      chk("stall_issue", 32'(mem_stall), 32'(!o.err));
      step();
      if (o.err) begin
         mem_valid = 1'b0;
         addr_err  = 1'b0;
         repeat (2) begin
            @(negedge clk);
            chk("stall_err", 32'(mem_stall), 0);
            chk("req_err", 32'(data_req), 0);
            step();
         end
         return;
      end
      req_q.push_back(model(o));
      cancelled = (o.f > 0);
      for (int j = 1; j <= o.a + o.d; j++) begin
         data_addr_ok = (j == o.a);
         data_data_ok = (j == o.a + o.d);
         flush        = (j == o.f);
         data_rdata   = (j == o.a + o.d) ? o.rd : $urandom;
         stall_other  = (j == o.a + o.d) && o.h > 0 && !cancelled;
         if (cancelled && j > o.f) apply(nx);
         @(negedge clk);
         chk("stall_busy", 32'(mem_stall), 1);
         chk("req_level", 32'(data_req), 32'(j <= o.a));
         step();
      end
      if (!cancelled) begin
         if (!o.wr) last_rd = o.rd;
         rd_q.push_back(last_rd);
      end
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      flush        = 1'b0;
      if (!cancelled) begin
         for (int i = 0; i < o.h; i++) begin
            stall_other = (i < o.h - 1);
            @(negedge clk);
            chk("stall_hold", 32'(mem_stall), 0);
            chk("req_hold", 32'(data_req), 0);
            chk("rdata_hold", rdata, last_rd);
            step();
         end
         stall_other = 1'b0;
         mem_valid   = 1'b0;
         for (int g = 0; g < o.gap; g++) begin
            @(negedge clk);
            chk("stall_gap", 32'(mem_stall), 0);
            step();
         end
      end
      stall_other = 1'b0;
   endtask

   function automatic op_t mk(logic wr, logic [1:0] sz,
                              logic [31:0] ad, logic [31:0] wd,
                              logic er, int a, int d, int f,
                              int h, logic [31:0] rd);
      op_t o;
      o.wr = wr; o.size = sz; o.addr = ad; o.wdata = wd;
      o.err = er; o.a = a; o.d = d; o.f = f; o.h = h;
      o.gap = 1; o.rd = rd;
      return o;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      op_t o, r;
      resetn = 1'b0;
      mem_valid = 0; mem_wr = 0; mem_size = 0; mem_addr = 0;
      mem_wdata = 0; addr_err = 0; flush = 0; stall_other = 0;
      data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
      #12;
      chk("rst_stall", 32'(mem_stall), 0);
      chk("rst_req", 32'(data_req), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_addr", data_addr, 0);
      step();
      resetn = 1'b1;
      step();

      ops.push_back(mk(0, 2, 32'h1000, 0, 0, 1, 2, 0, 0,
                       32'hDEADBEEF));
      ops.push_back(mk(1, 0, 32'h1003, 32'hA5, 0, 1, 0, 0, 0,
                       32'h0));
      ops.push_back(mk(0, 1, 32'h1001, 0, 1, 1, 0, 0, 0, 32'h0));
      ops.push_back(mk(0, 2, 32'h2000, 0, 0, 1, 3, 2, 0,
                       32'h11112222));
      ops.push_back(mk(0, 2, 32'h2004, 0, 0, 2, 1, 0, 3,
                       32'h33334444));
      for (int k = 0; k < 60; k++) begin
         r = mk($urandom_range(0, 1), 2'($urandom_range(0, 3)),
                $urandom, $urandom, ($urandom % 8) == 0,
                $urandom_range(1, 3), $urandom_range(0, 3), 0,
                0, $urandom);
         if ($urandom % 4 == 0)
            r.f = $urandom_range(1, r.a + r.d);
         if ($urandom % 3 == 0) r.h = $urandom_range(1, 3);
         r.gap = $urandom_range(0, 2);
         ops.push_back(r);
      end
      ops[ops.size()-1].f = 0;
      ops.push_back(mk(0, 2, 32'h0, 0, 0, 1, 0, 0, 0, 32'h0));
      for (int k = 0; k < ops.size() - 1; k++)
         run_op(ops[k], ops[k+1]);
      mem_valid = 1'b0;
      addr_err  = 1'b0;
      step();

      o = mk(0, 2, 32'h3000, 0, 0, 1, 5, 0, 0, 32'h0);
      apply(o);
      step();
      req_q.push_back(model(o));
      mem_valid    = 1'b0;
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0;
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_stall", 32'(mem_stall), 0);
      chk("arst_rvalid", 32'(rdata_valid), 0);
      chk("arst_rdata", rdata, 0);
      chk("arst_req", 32'(data_req), 0);
      chk("arst_wr", 32'(data_wr), 0);
      chk("arst_size", 32'(data_size), 0);
      chk("arst_addr", data_addr, 0);
      chk("arst_wstrb", 32'(data_wstrb), 0);
      chk("arst_wdata", data_wdata, 0);
      step();
      resetn       = 1'b1;
      data_data_ok = 1'b1;
      data_rdata   = 32'hCAFEF00D;
      step();
      data_data_ok = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("late_rvalid", 32'(rdata_valid), 0);
         chk("late_stall", 32'(mem_stall), 0);
         chk("late_rdata", rdata, 0);
         step();
      end

      chk("req_q_empty", req_q.size(), 0);
      chk("rd_q_empty", rd_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
